// File: rtl/apb_uart_ctrl_pkg.sv
// rtl/apb_uart_ctrl_pkg.sv - shared types and constants for the APB UART master controller
package apb_uart_ctrl_pkg;

    localparam int APB_ADDR_W  = 32;
    localparam int APB_DATA_W  = 32;
    localparam int OWNER_IDX_W = 3;

    localparam logic [APB_ADDR_W-1:0] DEFAULT_INT_STAT_ADDR = 32'h0000_0010;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } ctrl_state_e;

    typedef struct packed {
        logic                   irq;
        logic [OWNER_IDX_W-1:0] idx;
    } owner_t;

endpackage

// File: rtl/apb_uart_ctrl_rr_arbiter.sv
// rtl/apb_uart_ctrl_rr_arbiter.sv - round-robin arbiter, search starts just after the pointer
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] pointer,
    input  logic             enable,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] winner
);

    int k;

    // Walk from farthest to nearest so the requester closest after the pointer wins.
    always_comb begin
        grant  = '0;
        winner = '0;
        k      = 0;
        if (enable) begin
            for (int i = NREQ; i >= 1; i--) begin
                k = (int'(pointer) + i) % NREQ;
                if (req[k]) begin
                    grant    = '0;
                    grant[k] = 1'b1;
                    winner   = IDX_W'(k);
                end
            end
        end
    end

endmodule

// File: rtl/apb_uart_ctrl.sv
// rtl/apb_uart_ctrl.sv - APB master sequencing requester and interrupt-status accesses to the UART
module apb_uart_ctrl
    import apb_uart_ctrl_pkg::*;
#(
    parameter int                    NREQ          = 2,
    parameter logic [APB_ADDR_W-1:0] INT_STAT_ADDR = DEFAULT_INT_STAT_ADDR,
    parameter bit                    IRQ_LOCKOUT   = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_i,
    input  logic [NREQ-1:0]            req_write_i,
    input  logic [NREQ*APB_ADDR_W-1:0] req_addr_i,
    input  logic [NREQ*APB_DATA_W-1:0] req_wdata_i,
    output logic [NREQ-1:0]            gnt_o,
    output logic [NREQ-1:0]            done_o,
    output logic [APB_DATA_W-1:0]      rdata_o,
    input  logic                       irq_en_i,
    output logic                       irq_stat_valid_o,
    output logic [APB_DATA_W-1:0]      irq_stat_o,
    output logic [APB_ADDR_W-1:0]      paddr_o,
    output logic [APB_DATA_W-1:0]      pwdata_o,
    output logic                       pwrite_o,
    output logic                       psel_o,
    output logic                       penable_o,
    input  logic [APB_DATA_W-1:0]      prdata_i,
    input  logic                       uart_int_i
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    ctrl_state_e           state_q, state_d;
    logic [IDX_W-1:0]      ptr_q;
    owner_t                owner_q;
    logic                  lockout_q;
    logic [APB_ADDR_W-1:0] addr_q;
    logic [APB_DATA_W-1:0] wdata_q;
    logic                  write_q;

    logic [NREQ-1:0]       arb_grant;
    logic [IDX_W-1:0]      arb_winner;
    logic                  irq_sel;
    logic                  arb_en;
    logic                  req_sel;
    logic [NREQ-1:0]       done_vec;

    // Interrupt service beats every requester whenever it is eligible.
    assign irq_sel = (state_q == IDLE) && irq_en_i && uart_int_i && !(IRQ_LOCKOUT && lockout_q);
    assign arb_en  = (state_q == IDLE) && !irq_sel && !rst;
    assign req_sel = |arb_grant;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req     (req_i),
        .pointer (ptr_q),
        .enable  (arb_en),
        .grant   (arb_grant),
        .winner  (arb_winner)
    );

    assign gnt_o     = arb_grant;
    assign psel_o    = (state_q != IDLE);
    assign penable_o = (state_q == ACCESS);
    assign paddr_o   = addr_q;
    assign pwdata_o  = wdata_q;
    assign pwrite_o  = write_q;

    always_comb begin
        done_vec = '0;
        for (int i = 0; i < NREQ; i++) begin
            done_vec[i] = (owner_q.idx == OWNER_IDX_W'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (irq_sel || req_sel) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q            <= IDX_W'(NREQ - 1);
            owner_q          <= '0;
            lockout_q        <= 1'b0;
            addr_q           <= '0;
            wdata_q          <= '0;
            write_q          <= 1'b0;
            done_o           <= '0;
            rdata_o          <= '0;
            irq_stat_valid_o <= 1'b0;
            irq_stat_o       <= '0;
        end else begin
            done_o           <= '0;
            irq_stat_valid_o <= 1'b0;

            if (irq_sel) begin
                addr_q  <= INT_STAT_ADDR;
                write_q <= 1'b0;
                owner_q <= '{irq: 1'b1, idx: '0};
            end else if (req_sel) begin
                addr_q  <= req_addr_i[int'(arb_winner)*APB_ADDR_W +: APB_ADDR_W];
                wdata_q <= req_wdata_i[int'(arb_winner)*APB_DATA_W +: APB_DATA_W];
                write_q <= req_write_i[arb_winner];
                owner_q <= '{irq: 1'b0, idx: OWNER_IDX_W'(arb_winner)};
                ptr_q   <= arb_winner;
            end

            if (state_q == ACCESS) begin
                if (owner_q.irq) begin
                    irq_stat_valid_o <= 1'b1;
                    irq_stat_o       <= prdata_i;
                end else begin
                    done_o <= done_vec;
                    if (!write_q) rdata_o <= prdata_i;
                end
            end

            // A low interrupt line always clears lockout; a finished IRQ read arms it.
            lockout_q <= IRQ_LOCKOUT && uart_int_i &&
                         (lockout_q || (state_q == ACCESS && owner_q.irq));
        end
    end

endmodule
